conv_pass_scheduler: RTL and testbench
======================================

CONV_PASS_SCHEDULER -- requirements
Module: conv_pass_scheduler

Interface
REQ-001 Parameter K, default 16: total number of filters in the layer; legal range 1..256.
REQ-002 Parameter N, default 4: number of parallel convolution engines; legal range 1..32.
REQ-003 Parameter MAX_CYCLES, default 4096: per-pass watchdog limit in clock cycles; legal range 2..65535.
REQ-004 Derived constant P = ceil(K/N): number of passes; derived constant SW = max(1, clog2(P)): width of the set index.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 start  input  1  request to run one full layer; sampled only in IDLE.
REQ-008 eng_done  input  N  per-engine completion; a level or a 1-cycle pulse, valid only while the scheduler is in RUN.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 done  output  1  1-cycle pulse when the layer finishes, normally or on timeout.
REQ-011 err  output  1  sticky timeout flag; cleared by the next accepted start.
REQ-012 eng_reset  output  1  engine clear; high for exactly one cycle at the start of each pass.
REQ-013 eng_active  output  N  mask of engines carrying a valid filter in the current pass.
REQ-014 filter_set  output  SW  current pass index; selects filters [filter_set*N +: N].
REQ-015 wr_en  output  1  1-cycle strobe to capture engine outputs into output slot filter_set.

Function
REQ-016 The scheduler SHALL implement the states IDLE, CLEAR, RUN, WRITE, NEXT and FIN.
REQ-017 IDLE: on start=1, go to CLEAR, set filter_set=0 and clear err.
REQ-018 CLEAR: assert eng_reset, clear the done-collector and the watchdog count, then go to RUN on the next cycle.
REQ-019 RUN: collect eng_done into sticky bits; leave when (sticky | eng_done) & eng_active == eng_active, evaluated in the same cycle.
REQ-020 eng_done bits of inactive engines SHALL be ignored.
REQ-021 RUN: the watchdog SHALL increment every cycle; when it reaches MAX_CYCLES-1 without completion, set err=1 and go to FIN with no wr_en.
REQ-022 If completion and timeout occur in the same cycle, completion SHALL win: go to WRITE, err stays 0.
REQ-023 WRITE: assert wr_en with the current filter_set value, then go to NEXT.
REQ-024 NEXT: if filter_set == P-1, go to FIN; otherwise increment filter_set and go to CLEAR.
REQ-025 FIN: pulse done=1 for one cycle, then go to IDLE.
REQ-026 eng_active SHALL be all-ones except in the last pass, where it is the low (K - (P-1)*N) bits; it is all-zero in IDLE.
REQ-027 When K is a multiple of N, the last pass SHALL be full.
REQ-028 Latency per pass SHALL be 1 (CLEAR) + R (RUN, R ≥ 1) + 1 (WRITE) + 1 (NEXT) cycles.
REQ-029 The start-to-done latency SHALL be the sum of the per-pass latencies plus 2 cycles (IDLE exit and FIN).
REQ-030 start asserted while busy SHALL be ignored and not queued.
REQ-031 filter_set SHALL be stable from CLEAR through WRITE of each pass and SHALL never exceed P-1 (no wrap).

Reset
REQ-032 While reset=1 at a clock edge, the scheduler SHALL go to IDLE and set filter_set=0, sticky bits=0 and watchdog=0.
REQ-033 While reset=1, busy, done, err, eng_reset, wr_en and eng_active SHALL all be 0.
REQ-034 Reset asserted mid-pass SHALL abort the layer with no wr_en or done pulse; the first legal start is on the cycle after reset deasserts.

Structure
REQ-035 The state encoding and the P/SW derivation functions SHALL live in the shared package conv_sched_pkg.
REQ-036 The sticky eng_done collection with active-mask compare SHALL be one sub-module, pass_done_collector (inputs clr, eng_done, eng_active; output all_done).
REQ-037 The top level SHALL hold only the FSM, the watchdog counter and the set counter; no arithmetic on filter data.

Verification
REQ-038 K=16, N=4, each engine pulses done 10 cycles after RUN entry -> 4 eng_reset pulses, wr_en with filter_set 0,1,2,3, one done pulse, err=0.
REQ-039 K=6, N=4 -> eng_active 4'b1111 then 4'b0011; a stray eng_done[3] in pass 1 is ignored; 2 wr_en pulses.
REQ-040 Engines finish at different cycles (staggered pulses 3,7,12) -> WRITE is entered the cycle after the last pulse.
REQ-041 MAX_CYCLES=20, engine 2 never done -> err=1 at RUN cycle 19, done pulses, no wr_en for that pass, the next start clears err.
REQ-042 Reset asserted in RUN of pass 2 -> all outputs 0 the next cycle, filter_set=0, no done; a restart completes normally.
REQ-043 start held high during the whole run -> exactly one layer executes; a new run starts only after IDLE is re-entered.

Source files
------------

// File: rtl/conv_sched_pkg.sv
// Shared definitions for the convolution pass scheduler: FSM encoding and
// the pass-count / set-index-width derivations.
package conv_sched_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StRun,
        StWrite,
        StNext,
        StFin
    } sched_state_e;

    localparam int unsigned WDOG_W = 16;

    function automatic int unsigned calc_passes(input int unsigned k, input int unsigned n);
        return (k + n - 1) / n;
    endfunction

    function automatic int unsigned calc_set_w(input int unsigned p);
        return (p > 1) ? $clog2(p) : 1;
    endfunction

endpackage

// File: rtl/pass_done_collector.sv
// Sticky per-engine completion collector; all_done compares against the
// active-engine mask so inactive engines never hold up or trigger a pass.
module pass_done_collector #(
    parameter int unsigned N = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic         i_clr,
    input  logic [N-1:0] i_eng_done,
    input  logic [N-1:0] i_eng_active,
    output logic         o_all_done
);

    logic [N-1:0] r_sticky;
    logic [N-1:0] w_seen;

    // Same-cycle eng_done counts, so a pass can finish on the pulse itself.
    assign w_seen     = (r_sticky | i_eng_done) & i_eng_active;
    assign o_all_done = (w_seen == i_eng_active);

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clr) begin
            r_sticky <= '0;
        end else begin
            r_sticky <= w_seen;
        end
    end

endmodule

// File: rtl/conv_pass_scheduler.sv
// Sequences a convolution layer over ceil(K/N) engine passes with a
// per-pass watchdog; holds only the FSM, the watchdog and the set counter.
module conv_pass_scheduler
    import conv_sched_pkg::*;
#(
    parameter int unsigned K          = 16,
    parameter int unsigned N          = 4,
    parameter int unsigned MAX_CYCLES = 4096,
    localparam int unsigned P         = calc_passes(K, N),
    localparam int unsigned SW        = calc_set_w(P)
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_start,
    input  logic [N-1:0]  i_eng_done,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err,
    output logic          o_eng_reset,
    output logic [N-1:0]  o_eng_active,
    output logic [SW-1:0] o_filter_set,
    output logic          o_wr_en
);

    localparam int unsigned           LAST     = K - (P - 1) * N;
    localparam logic [SW-1:0]         SET_LAST = SW'(P - 1);
    localparam logic [WDOG_W-1:0]     WDOG_LIM = WDOG_W'(MAX_CYCLES - 1);

    sched_state_e      r_state;
    sched_state_e      w_state_next;
    logic [SW-1:0]     r_set;
    logic [WDOG_W-1:0] r_wdog;
    logic              r_err;
    logic [N-1:0]      w_last_mask;
    logic [N-1:0]      w_active;
    logic              w_all_done;
    logic              w_timeout;

    always_comb begin
        w_last_mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            w_last_mask[i] = (i < int'(LAST));
        end
    end

    assign w_active  = (r_set == SET_LAST) ? w_last_mask : '1;
    assign w_timeout = (r_wdog == WDOG_LIM);

    pass_done_collector #(
        .N (N)
    ) u_collector (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clr        (r_state == StClear),
        .i_eng_done   (i_eng_done),
        .i_eng_active (w_active),
        .o_all_done   (w_all_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Completion is tested before the watchdog so a last-cycle finish still writes.
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:  if (i_start) w_state_next = StClear;
            StClear: w_state_next = StRun;
            StRun: begin
                if (w_all_done) begin
                    w_state_next = StWrite;
                end else if (w_timeout) begin
                    w_state_next = StFin;
                end
            end
            StWrite: w_state_next = StNext;
            StNext:  w_state_next = (r_set == SET_LAST) ? StFin : StClear;
            StFin:   w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_set  <= '0;
            r_wdog <= '0;
            r_err  <= 1'b0;
        end else begin
            if (r_state == StIdle && i_start) begin
                r_set <= '0;
                r_err <= 1'b0;
            end
            if (r_state == StNext && r_set != SET_LAST) begin
                r_set <= r_set + 1'b1;
            end
            if (r_state == StClear) begin
                r_wdog <= '0;
            end else if (r_state == StRun) begin
                r_wdog <= r_wdog + 1'b1;
            end
            if (r_state == StRun && !w_all_done && w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    // Reset forces every control output low in the same cycle.
    always_comb begin
        o_busy       = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_eng_reset  = 1'b0;
        o_wr_en      = 1'b0;
        o_eng_active = '0;
        if (!i_reset) begin
            o_busy      = (r_state != StIdle);
            o_done      = (r_state == StFin);
            o_err       = r_err;
            o_eng_reset = (r_state == StClear);
            o_wr_en     = (r_state == StWrite);
            if (r_state != StIdle) begin
                o_eng_active = w_active;
            end
        end
    end

    assign o_filter_set = r_set;

endmodule

// File: tb/tb_conv_pass_scheduler.sv
// Randomized bench: a per-layer timeline model built from engine finish delays
// predicts every output cycle by cycle.
module tb_conv_pass_scheduler;

    localparam int K     = 10;
    localparam int N     = 4;
    localparam int MC    = 20;
    localparam int P     = (K + N - 1) / N;
    localparam int SW    = (P > 1) ? $clog2(P) : 1;
    localparam int LAST  = K - (P - 1) * N;
    localparam int NEVER = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [N-1:0]  eng_done;
    logic          busy, done, err, eng_reset, wr_en;
    logic [N-1:0]  eng_active;
    logic [SW-1:0] filter_set;

    always #5 clk = ~clk;

    conv_pass_scheduler #(
        .K          (K),
        .N          (N),
        .MAX_CYCLES (MC)
    ) dut (
        .i_clk        (clk),
        .i_reset      (rst),
        .i_start      (start),
        .i_eng_done   (eng_done),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err),
        .o_eng_reset  (eng_reset),
        .o_eng_active (eng_active),
        .o_filter_set (filter_set),
        .o_wr_en      (wr_en)
    );

    typedef struct {
        logic         start;
        logic [N-1:0] drv;
        logic         busy, done, err, ers, wr;
        logic [N-1:0] act;
        int           set;
    } step_t;

    step_t trace[$];
    int    dly[P][N];
    int    n_checks = 0;
    int    n_fail   = 0;
    logic  prev_err = 1'b0;
    int    abort_idx;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] mask_of(input int p);
        logic [N-1:0] m;
        for (int e = 0; e < N; e++) m[e] = (p != P - 1) || (e < LAST);
        return m;
    endfunction

    task automatic fill_dly(input int lo, input int hi);
        for (int p = 0; p < P; p++)
            for (int e = 0; e < N; e++) dly[p][e] = int'($urandom_range(hi, lo));
    endtask

    // Timeline: IDLE(start) then per pass CLEAR, R x RUN, WRITE, NEXT; FIN; one IDLE.
    task automatic build(input bit hold, input bit level, input bit noise, input int abort_pass);
        step_t        s;
        logic [N-1:0] m;
        int           dmax, r_len;
        bit           tout;
        bit           layer_err = 1'b0;
        trace.delete();
        abort_idx = -1;
        s = '{default: '0};
        s.start = 1'b1;
        s.err   = prev_err;
        trace.push_back(s);
        for (int p = 0; p < P; p++) begin
            m    = mask_of(p);
            dmax = 0;
            for (int e = 0; e < N; e++) if (m[e] && dly[p][e] > dmax) dmax = dly[p][e];
            tout  = (dmax >= MC);
            r_len = tout ? MC : dmax + 1;
            s = '{default: '0};
            s.busy = 1'b1; s.act = m; s.set = p; s.ers = 1'b1;
            s.start = hold | (noise & ($urandom_range(3, 0) == 0));
            trace.push_back(s);
            for (int r = 0; r < r_len; r++) begin
                s = '{default: '0};
                s.busy = 1'b1; s.act = m; s.set = p;
                s.start = hold | (noise & ($urandom_range(3, 0) == 0));
                for (int e = 0; e < N; e++) begin
                    if (m[e]) s.drv[e] = level ? (r >= dly[p][e]) : (r == dly[p][e]);
                    else      s.drv[e] = noise ? 1'($urandom_range(1, 0)) : 1'b0;
                end
                if (p == abort_pass && r == 2) abort_idx = trace.size();
                trace.push_back(s);
            end
            s = '{default: '0};
            s.busy = 1'b1; s.act = m; s.set = p; s.start = hold;
            if (tout) begin
                layer_err = 1'b1;
                s.done = 1'b1; s.err = 1'b1;
                trace.push_back(s);
                break;
            end
            s.wr = 1'b1;
            trace.push_back(s);
            s.wr = 1'b0;
            trace.push_back(s);
            if (p == P - 1) begin
                s.done = 1'b1;
                trace.push_back(s);
            end
        end
        s = '{default: '0};
        s.err = layer_err;
        trace.push_back(s);
        prev_err = layer_err;
    endtask

    task automatic execute();
        for (int i = 0; i < trace.size(); i++) begin
            if (i == abort_idx) begin
                rst = 1'b1; start = 1'b0; eng_done = trace[i].drv;
                @(negedge clk);
                check_eq("rst_busy", 32'(busy), 32'd0);
                check_eq("rst_done", 32'(done), 32'd0);
                check_eq("rst_err", 32'(err), 32'd0);
                check_eq("rst_eng_reset", 32'(eng_reset), 32'd0);
                check_eq("rst_wr_en", 32'(wr_en), 32'd0);
                check_eq("rst_eng_active", 32'(eng_active), 32'd0);
                @(posedge clk); #1;
                rst = 1'b0; eng_done = '0;
                @(negedge clk);
                check_eq("abort_busy", 32'(busy), 32'd0);
                check_eq("abort_done", 32'(done), 32'd0);
                check_eq("abort_set", 32'(filter_set), 32'd0);
                check_eq("abort_active", 32'(eng_active), 32'd0);
                @(posedge clk); #1;
                prev_err = 1'b0;
                return;
            end
            start    = trace[i].start;
            eng_done = trace[i].drv;
            @(negedge clk);
            check_eq($sformatf("busy@%0d", i), 32'(busy), 32'(trace[i].busy));
            check_eq($sformatf("done@%0d", i), 32'(done), 32'(trace[i].done));
            check_eq($sformatf("err@%0d", i), 32'(err), 32'(trace[i].err));
            check_eq($sformatf("eng_reset@%0d", i), 32'(eng_reset), 32'(trace[i].ers));
            check_eq($sformatf("wr_en@%0d", i), 32'(wr_en), 32'(trace[i].wr));
            check_eq($sformatf("eng_active@%0d", i), 32'(eng_active), 32'(trace[i].act));
            if (trace[i].busy)
                check_eq($sformatf("filter_set@%0d", i), 32'(filter_set), 32'(trace[i].set));
            @(posedge clk); #1;
        end
        start = 1'b0; eng_done = '0;
    endtask

    task automatic run_layer(input bit hold, input bit level, input bit noise, input int abort_pass);
        build(hold, level, noise, abort_pass);
        execute();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; eng_done = '0;
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("reset_busy", 32'(busy), 32'd0);
        check_eq("reset_done", 32'(done), 32'd0);
        check_eq("reset_err", 32'(err), 32'd0);
        check_eq("reset_eng_reset", 32'(eng_reset), 32'd0);
        check_eq("reset_wr_en", 32'(wr_en), 32'd0);
        check_eq("reset_eng_active", 32'(eng_active), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("idle_busy", 32'(busy), 32'd0);
        check_eq("idle_set", 32'(filter_set), 32'd0);
        @(posedge clk); #1;

        fill_dly(10, 10);
        run_layer(1'b0, 1'b0, 1'b0, -1);

        // Staggered finishes, then a pass finishing on the watchdog's last cycle.
        fill_dly(0, 8);
        dly[0] = '{3, 7, 12, 5};
        dly[1] = '{19, 2, 4, 0};
        run_layer(1'b0, 1'b0, 1'b1, -1);

        fill_dly(0, 8);
        dly[1][2] = NEVER;
        run_layer(1'b0, 1'b1, 1'b0, -1);

        fill_dly(0, 8);
        run_layer(1'b0, 1'b0, 1'b1, -1);

        fill_dly(0, 8);
        run_layer(1'b1, 1'b0, 1'b0, -1);

        fill_dly(3, 10);
        run_layer(1'b0, 1'b0, 1'b0, 2);
        fill_dly(0, 8);
        run_layer(1'b0, 1'b1, 1'b1, -1);

        repeat (10) begin
            fill_dly(0, 22);
            run_layer(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
